// File: rtl/sram_ctrl_pkg.sv
// Shared types and timing helpers for the burst SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WR      = 3'd2,
        ST_WR_WAIT = 3'd3,
        ST_TURN    = 3'd4
    } state_t;

    // Nanoseconds to whole clock cycles, rounded up.
    function automatic int unsigned ns2cyc(input int unsigned ns, input int unsigned clk_period);
        return (ns + clk_period - 1) / clk_period;
    endfunction

    function automatic int unsigned max_f(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned rd_cyc_f(input int unsigned t_rc, input int unsigned clk_period);
        return ns2cyc(t_rc, clk_period);
    endfunction

    function automatic int unsigned wp_cyc_f(input int unsigned t_wp, input int unsigned clk_period);
        return ns2cyc(t_wp, clk_period);
    endfunction

    // Write cycle must leave one setup and one hold cycle around the WE pulse.
    function automatic int unsigned wc_cyc_f(input int unsigned t_wc, input int unsigned t_wp,
                                             input int unsigned clk_period);
        return max_f(ns2cyc(t_wc, clk_period), ns2cyc(t_wp, clk_period) + 2);
    endfunction

endpackage

// File: rtl/sram_burst_ctrl_if.sv
// Avalon-MM burst slave bundle between interconnect and the SRAM controller.
interface sram_burst_ctrl_if #(
    parameter int unsigned ADDR_W  = 18,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned BURST_W = 4
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0]  avs_address;
    logic               avs_read;
    logic               avs_write;
    logic [DATA_W-1:0]  avs_writedata;
    logic [BE_W-1:0]    avs_byteenable;
    logic [BURST_W-1:0] avs_burstcount;
    logic               avs_waitrequest;
    logic [DATA_W-1:0]  avs_readdata;
    logic               avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
        input  avs_waitrequest, avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable, avs_burstcount,
        output avs_waitrequest, avs_readdata, avs_readdatavalid
    );
endinterface

// File: rtl/sram_cycle_timer.sv
// Loadable down-counter timing the RD, WR and TURN phases.
module sram_cycle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    // Count down to zero after a load; done flags the final cycle of a phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
        end else if (start_i) begin
            cnt_q  <= load_val_i;
            done_q <= (load_val_i == '0);
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = done_q;
endmodule

// File: rtl/sram_burst_ctrl.sv
// Avalon-MM burst slave driving an asynchronous SRAM with byte lanes.
module sram_burst_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned CLK_PERIOD = 10,
    parameter int unsigned ADDR_W     = 18,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BE_W       = DATA_W / 8,
    parameter int unsigned BURST_W    = 4,
    parameter int unsigned T_RC       = 55,
    parameter int unsigned T_WC       = 55,
    parameter int unsigned T_WP       = 40,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    sram_burst_ctrl_if.slave  avs,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic              sram_ce_n_o,
    output logic              sram_we_n_o,
    output logic              sram_oe_n_o,
    output logic [BE_W-1:0]   sram_be_n_o,
    output logic              sram_data_en_o,
    output logic [DATA_W-1:0] sram_data_o,
    input  logic [DATA_W-1:0] sram_data_i
);
    localparam int unsigned RD_CYC = rd_cyc_f(T_RC, CLK_PERIOD);
    localparam int unsigned WP_CYC = wp_cyc_f(T_WP, CLK_PERIOD);
    localparam int unsigned WC_CYC = wc_cyc_f(T_WC, T_WP, CLK_PERIOD);
    localparam int unsigned TN_CYC = max_f(TURN_CYC, 1);
    localparam int unsigned TMR_W  = $clog2(max_f(max_f(RD_CYC, WC_CYC), TN_CYC) + 1);

    localparam logic [TMR_W-1:0] RD_LOAD = TMR_W'(RD_CYC - 1);
    localparam logic [TMR_W-1:0] WC_LOAD = TMR_W'(WC_CYC - 1);
    localparam logic [TMR_W-1:0] TN_LOAD = TMR_W'(TN_CYC - 1);
    // WE is low in the cycle after any count at or above this value.
    localparam logic [TMR_W-1:0] WE_FROM = TMR_W'(WC_CYC - WP_CYC);

    state_t              state_q, state_d;
    logic [BURST_W-1:0]  beats_q, beats_d, beats_first;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                den_q, den_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                waitreq_q, waitreq_d;
    logic [DATA_W-1:0]   rdata_q;
    logic                rd_pend_q, rdvalid_q;
    logic                rd_cap, tmr_start, tmr_done, cmd_acc;
    logic [TMR_W-1:0]    tmr_load, tmr_cnt;

    sram_cycle_timer #(.CNT_W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .start_i    (tmr_start),
        .load_val_i (tmr_load),
        .cnt_o      (tmr_cnt),
        .done_o     (tmr_done)
    );

    assign cmd_acc     = (avs.avs_read | avs.avs_write) & ~waitreq_q;
    assign beats_first = (avs.avs_burstcount == '0) ? BURST_W'(1) : avs.avs_burstcount;

    // Next state plus the pad/handshake values that go with it.
    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        addr_d    = addr_q;
        ce_n_d    = ce_n_q;
        we_n_d    = 1'b1;
        oe_n_d    = oe_n_q;
        be_n_d    = be_n_q;
        den_d     = den_q;
        dout_d    = dout_q;
        waitreq_d = waitreq_q;
        rd_cap    = 1'b0;
        tmr_start = 1'b0;
        tmr_load  = '0;
        case (state_q)
            ST_IDLE: begin
                waitreq_d = 1'b0;
                if (cmd_acc) begin
                    addr_d    = avs.avs_address;
                    beats_d   = beats_first;
                    waitreq_d = 1'b1;
                    ce_n_d    = 1'b0;
                    tmr_start = 1'b1;
                    if (avs.avs_write) begin
                        state_d  = ST_WR;
                        tmr_load = WC_LOAD;
                        den_d    = 1'b1;
                        dout_d   = avs.avs_writedata;
                        be_n_d   = ~avs.avs_byteenable;
                        oe_n_d   = 1'b1;
                    end else begin
                        state_d  = ST_RD;
                        tmr_load = RD_LOAD;
                        oe_n_d   = 1'b0;
                        be_n_d   = '0;
                        den_d    = 1'b0;
                    end
                end
            end
            ST_RD: begin
                if (tmr_done) begin
                    rd_cap    = 1'b1;
                    tmr_start = 1'b1;
                    if (beats_q > BURST_W'(1)) begin
                        beats_d  = beats_q - BURST_W'(1);
                        addr_d   = addr_q + ADDR_W'(1);
                        tmr_load = RD_LOAD;
                    end else begin
                        state_d  = ST_TURN;
                        tmr_load = TN_LOAD;
                        ce_n_d   = 1'b1;
                        oe_n_d   = 1'b1;
                        be_n_d   = '1;
                    end
                end
            end
            ST_WR: begin
                we_n_d = (tmr_cnt < WE_FROM);
                if (tmr_done) begin
                    be_n_d = '1;
                    if (beats_q > BURST_W'(1)) begin
                        state_d   = ST_WR_WAIT;
                        beats_d   = beats_q - BURST_W'(1);
                        addr_d    = addr_q + ADDR_W'(1);
                        waitreq_d = 1'b0;
                    end else begin
                        state_d   = ST_TURN;
                        tmr_start = 1'b1;
                        tmr_load  = TN_LOAD;
                        ce_n_d    = 1'b1;
                        den_d     = 1'b0;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (avs.avs_write) begin
                    state_d   = ST_WR;
                    waitreq_d = 1'b1;
                    dout_d    = avs.avs_writedata;
                    be_n_d    = ~avs.avs_byteenable;
                    tmr_start = 1'b1;
                    tmr_load  = WC_LOAD;
                end
            end
            ST_TURN: begin
                if (tmr_done) begin
                    state_d   = ST_IDLE;
                    waitreq_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                ce_n_d    = 1'b1;
                oe_n_d    = 1'b1;
                be_n_d    = '1;
                den_d     = 1'b0;
                waitreq_d = 1'b1;
            end
        endcase
    end

    // State and registered pad/handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            beats_q   <= '0;
            addr_q    <= '0;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            be_n_q    <= '1;
            den_q     <= 1'b0;
            dout_q    <= '0;
            waitreq_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            addr_q    <= addr_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            oe_n_q    <= oe_n_d;
            be_n_q    <= be_n_d;
            den_q     <= den_d;
            dout_q    <= dout_d;
            waitreq_q <= waitreq_d;
        end
    end

    // Read return: capture pads at end of a read cycle, flag valid one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= '0;
            rd_pend_q <= 1'b0;
            rdvalid_q <= 1'b0;
        end else begin
            if (rd_cap) begin
                rdata_q <= sram_data_i;
            end
            rd_pend_q <= rd_cap;
            rdvalid_q <= rd_pend_q;
        end
    end

    assign avs.avs_waitrequest   = waitreq_q;
    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rdvalid_q;
    assign sram_addr_o           = addr_q;
    assign sram_ce_n_o           = ce_n_q;
    assign sram_we_n_o           = we_n_q;
    assign sram_oe_n_o           = oe_n_q;
    assign sram_be_n_o           = be_n_q;
    assign sram_data_en_o        = den_q;
    assign sram_data_o           = dout_q;
endmodule

// File: doc/sram_burst_ctrl.md
Name: sram_burst_ctrl

Overview:
- Avalon-MM slave (burst, byteenable, pipelined read) driving an asynchronous 16-bit-class SRAM (e.g. 256Kx16 MoBL) with per-byte lane strobes, chip enable and a tri-state data bus.
- Successor to the single-word sram_controller.
- Access timing is derived from nanosecond parameters and CLK_PERIOD.
- Adds bursts, byte lanes, a write-recovery phase and bus turnaround.
- Sits between the system interconnect and the top-level SRAM pads; the tri-state buffer lives outside the block.

Parameters:
- CLK_PERIOD, 10, clock period in ns.
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, data width; multiple of 8.
- BE_W, DATA_W/8, byte lanes.
- BURST_W, 4, burstcount width; max burst 2^(BURST_W-1).
- T_RC, 55, read cycle time, ns.
- T_WC, 55, write cycle time, ns.
- T_WP, 40, WE low pulse width, ns.
- TURN_CYC, 1, idle cycles after every command before the next may start.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- avs_address  in  ADDR_W  start word address; sampled on command accept
- avs_read  in  1  read request
- avs_write  in  1  write request / write beat valid
- avs_writedata  in  DATA_W  write beat data
- avs_byteenable  in  BE_W  per-beat byte lanes
- avs_burstcount  in  BURST_W  beats; sampled on command accept
- avs_waitrequest  out  1  stall
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  one-cycle pulse per read beat
- sram_addr_o  out  ADDR_W  SRAM address
- sram_ce_n_o  out  1  chip enable, active low
- sram_we_n_o  out  1  write enable, active low
- sram_oe_n_o  out  1  output enable, active low
- sram_be_n_o  out  BE_W  byte lane enables, active low
- sram_data_en_o  out  1  drive enable for the external tri-state
- sram_data_o  out  DATA_W  write data to pads
- sram_data_i  in  DATA_W  read data from pads

Behaviour:

Cycle counts (elaboration-time constants):
- RD_CYC = ceil(T_RC/CLK_PERIOD)
- WP_CYC = ceil(T_WP/CLK_PERIOD)
- WC_CYC = max(ceil(T_WC/CLK_PERIOD), WP_CYC+2)
- Defaults give RD_CYC=6, WP_CYC=4, WC_CYC=6.

Reset (rst=0, asynchronous):
- avs_waitrequest=1, avs_readdatavalid=0, avs_readdata=0.
- ce_n=we_n=oe_n=1, be_n all 1.
- data_en=0, addr=0, data_o=0.
- FSM goes to IDLE.
- Reset mid-burst drops all strobes immediately. The remaining beats are discarded and no readdatavalid is issued for them.

All outputs are registered. States: IDLE, RD, WR, WR_WAIT, TURN.

IDLE:
- waitrequest=0 and all strobes inactive.
- Command accept = (avs_read|avs_write) && !waitrequest.
- On accept: latch address, beats = burstcount (0 is treated as 1), and the first writedata/byteenable for writes.
- If avs_read and avs_write are both asserted, write wins and the read is ignored; this is a master protocol violation.

RD:
- ce_n=0, oe_n=0, be_n all 0, data_en=0; the address is held for RD_CYC cycles.
- On the last cycle, sram_data_i is registered into avs_readdata and avs_readdatavalid pulses the following cycle.
- If beats remain: address increments (wrapping modulo 2^ADDR_W) and RD restarts with no gap.
- Otherwise go to TURN.
- Single-read latency: readdatavalid asserts RD_CYC+1 cycles after the accept edge.
- waitrequest=1 for the whole state.

WR (WC_CYC cycles):
- ce_n=0, data_en=1, data_o = latched data, be_n = ~latched byteenable, oe_n=1.
- Cycle 0 is address setup, with we_n=1.
- Cycles 1..WP_CYC have we_n=0.
- The remaining cycles have we_n=1, holding data and address.
- byteenable=0 still runs the full cycle with be_n all 1, writes nothing, and counts as a beat.
- Then: if beats remain go to WR_WAIT, otherwise go to TURN.

WR_WAIT:
- waitrequest=0 and we_n=1; the address is incremented on entry.
- Waits for avs_write=1.
- On accept, latch writedata/byteenable and go to WR.
- avs_read here is ignored; waitrequest is low but no read is accepted.

TURN:
- TURN_CYC cycles with ce_n=1, data_en=0, waitrequest=1, then IDLE.
- This guarantees bus release between a write and a following read.

Invariants:
- we_n and oe_n are never both low.
- data_en=1 never coincides with oe_n=0.
- Address and byte lanes are stable whenever we_n=0.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state_t enum;
  - a function ns2cyc(ns, clk_period) returning ceil;
  - the RD_CYC/WP_CYC/WC_CYC localparam derivation helpers.
- Sub-module sram_cycle_timer: a loadable down-counter with load value, start and done. It is shared by RD, WR and TURN, and exposes the current count so the FSM can decode the WE window.

Test Plan:
- Single read: write 0xA5C3 to address 0x00010, then read burstcount=1 -> readdatavalid exactly 7 cycles after the accept, readdata=0xA5C3, oe_n low for 6 cycles.
- Write burst: 4 beats at address 0x3FFFE with data 0x1111..0x4444 -> SRAM addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001 hold them (wrap). Each we_n pulse lasts 4 cycles. Readback in a 4-beat read gives 4 back-to-back valid pulses spaced 6 cycles apart.
- Byte lanes: write 0xFFFF to address 5, then write 0x1234 with byteenable=2'b01 -> be_n=2'b10 during the pulse; a read returns 0xFF34. A write with byteenable=0 leaves 0xFF34 unchanged.
- Stalled write burst: the master deasserts avs_write for 5 cycles between beats 2 and 3 -> the controller sits in WR_WAIT with we_n=1 and ce_n=0, and completes correctly afterwards.
- Reset mid-operation: assert rst during cycle 3 of an 8-beat read -> all strobes deassert in the same time step, no further readdatavalid appears, and after release waitrequest=0 in IDLE.
- Write then read back-to-back: data_en falls at least TURN_CYC cycles before oe_n falls. A protocol checker asserts the invariants for 200 random transactions against the SRAM model.
